// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit timing.
// Reused by the transmitter so both ends agree on baud and state numbering.
package uart_defs;

  localparam int CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
    STOP_BIT   = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so an idle-high line comes out of reset idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first, framing-error and break detection.
// rx_byte only changes on a good frame; rx_dv/rx_frame_err are one-cycle pulses.
module uart_rx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic       rx_dv,
  output logic [7:0] rx_byte,
  output logic       rx_active,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic rx_sync;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx_serial),
    .q_o  (rx_sync)
  );

  uart_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    byte_q;
  logic          dv_q;
  logic          ferr_q;
  logic          active_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!rx_sync) begin
            state_q  <= START_BIT;
            active_q <= 1'b1;
          end
        end
        START_BIT: begin
          if (cnt_q == HALF_C) begin
            cnt_q <= '0;
            if (!rx_sync) begin
              state_q <= DATA_BITS;
            end else begin
              // too short to be a real start bit
              state_q  <= IDLE;
              active_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        DATA_BITS: begin
          if (cnt_q == LAST_C) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_sync;
            if (idx_q == 3'd7) begin
              state_q <= STOP_BIT;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        STOP_BIT: begin
          if (cnt_q == LAST_C) begin
            cnt_q <= '0;
            if (rx_sync) begin
              byte_q   <= shift_q;
              dv_q     <= 1'b1;
              state_q  <= IDLE;
              active_q <= 1'b0;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + ONE_C;
          end
        end
        BREAK_WAIT: begin
          if (rx_sync) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          idx_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_dv        = dv_q;
  assign rx_byte      = byte_q;
  assign rx_active    = active_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames driven, expected pulses queued.
// A negedge monitor pops and compares kind, byte and arrival cycle.
module tb_uart_rx;

  localparam int CPB  = 8;
  localparam int HALF = (CPB - 1) / 2;
  // line change after edge k -> FSM sees it at k+3, pulse after k+4+HALF+9*CPB
  localparam int LAT  = 4 + HALF + 9 * CPB;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_active;
  logic       rx_frame_err;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  exp_t       q[$];
  logic [7:0] model_byte = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_serial   (rx_serial),
    .rx_dv       (rx_dv),
    .rx_byte     (rx_byte),
    .rx_active   (rx_active),
    .rx_frame_err(rx_frame_err)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_dv", int'(rx_dv), 0);
    check("rst_byte", int'(rx_byte), 0);
    check("rst_active", int'(rx_active), 0);
    check("rst_ferr", int'(rx_frame_err), 0);
  endtask

  // One 8N1 frame; a bad stop bit is held low for hold cycles (a break).
  task automatic send(input logic [7:0] d, input bit stop_ok, input int hold);
    exp_t e;
    e.err  = !stop_ok;
    e.data = stop_ok ? d : model_byte;
    e.cyc  = cyc + LAT;
    q.push_back(e);
    if (stop_ok) model_byte = d;
    rx_serial = 1'b0;
    tick(CPB);
    check("active_mid", int'(rx_active), 1);
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      tick(CPB);
    end
    rx_serial = stop_ok;
    tick(stop_ok ? CPB : hold);
    rx_serial = 1'b1;
  endtask

  task automatic glitch(input int len);
    rx_serial = 1'b0;
    tick(len);
    rx_serial = 1'b1;
    tick(CPB * 2);
    check("glitch_active", int'(rx_active), 0);
    check("glitch_byte", int'(rx_byte), int'(model_byte));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rx_dv && rx_frame_err) begin
        vectors++;
        miscompares++;
        $display("FAIL dv_and_ferr: both high at cycle %0d", cyc);
      end
      if (rx_dv || rx_frame_err) begin
        if (q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: dv=%0b ferr=%0b byte=%0h at cycle %0d",
                   rx_dv, rx_frame_err, rx_byte, cyc);
        end else begin
          e = q.pop_front();
          check("pulse_kind", int'(rx_frame_err), int'(e.err));
          check("rx_byte", int'(rx_byte), int'(e.data));
          check("latency", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    int r;
    rst_n = 1'b0;
    tick(5);
    check_reset_vals();
    rst_n = 1'b1;
    tick(4);

    send(8'hA5, 1'b1, 0);
    tick(3);

    rx_serial = 1'b0;
    tick(2);
    rx_serial = 1'b1;
    tick(3);
    check("glitch_seen", int'(rx_active), 1);
    tick(CPB * 2);
    check("glitch_idle", int'(rx_active), 0);
    check("glitch_keep", int'(rx_byte), 8'hA5);

    send(8'h11, 1'b1, 0);
    tick(2);
    send(8'h3C, 1'b0, 40);
    check("break_active", int'(rx_active), 1);
    tick(6);
    check("break_done", int'(rx_active), 0);
    check("break_keep", int'(rx_byte), 8'h11);
    tick(CPB);

    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    tick(2 * CPB);

    d = 8'h5A;
    rx_serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_serial = d[i];
      tick(CPB);
    end
    rx_serial = d[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    tick(2);
    rx_serial = 1'b1;
    tick(3);
    check_reset_vals();
    model_byte = 8'h00;
    rst_n = 1'b1;
    tick(2 * CPB);
    send(8'hC3, 1'b1, 0);
    tick(2 * CPB);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r == 0) begin
        glitch($urandom_range(1, HALF));
      end else if (r == 1) begin
        send(d, 1'b0, $urandom_range(CPB, 40));
        tick(CPB);
      end else begin
        send(d, 1'b1, 0);
        if (r > 5) tick($urandom_range(1, 3 * CPB));
      end
    end

    for (int t = 0; t < 400 && q.size() != 0; t++) tick(1);
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: byte %0h err=%0b due cycle %0d", e.data, e.err, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
